// File: rtl/trg_pkg.sv
// Shared definitions for the trigger arbiter: register map, FSM encoding,
// default read value and small helpers.
package trg_pkg;

    localparam logic [7:0] ADDR_STATUS  = 8'h00;
    localparam logic [7:0] ADDR_MASK    = 8'h01;
    localparam logic [7:0] ADDR_CMD     = 8'h02;
    localparam logic [7:0] ADDR_HOLDOFF = 8'h03;
    localparam logic [7:0] ADDR_TRGCNT  = 8'h04;
    localparam logic [7:0] ADDR_LOSTCNT = 8'h05;
    localparam logic [7:0] ADDR_TRGID   = 8'h06;

    localparam logic [15:0] CMD_CLEAR  = 16'h0001;
    localparam logic [15:0] RD_DEFAULT = 16'hF001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FIRE    = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_UNUSED  = 2'd3
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [15:0] sat_add(
        input logic [15:0] a,
        input logic [3:0]  b
    );
        logic [16:0] s;
        s = {1'b0, a} + {13'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/trg_rr_arb.sv
// Combinational round-robin arbiter: search starts at ptr_i and wraps.
// Ports: req_i request vector, ptr_i start index, gnt_o one-hot, idx_o index.
module trg_rr_arb
    import trg_pkg::*;
#(
    parameter int NSRC = 4,
    parameter int IW   = idx_w(NSRC)
) (
    input  logic [NSRC-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NSRC-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);

    logic          found;
    int            j;
    logic [IW-1:0] jj;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        jj    = '0;
        for (int i = 0; i < NSRC; i++) begin
            j = int'(ptr_i) + i;
            if (j >= NSRC) j = j - NSRC;
            jj = IW'(j);
            if (!found && req_i[jj]) begin
                found     = 1'b1;
                gnt_o[jj] = 1'b1;
                idx_o     = jj;
            end
        end
    end

endmodule

// File: rtl/trg_arb.sv
// Trigger arbiter: merges masked request sources, applies busy veto and
// holdoff spacing, issues trg_o/trg_src_o/trg_id_o; register bus config.
module trg_arb
    import trg_pkg::*;
#(
    parameter int NSRC = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            reg_we_i,
    input  logic [7:0]      reg_addr_i,
    input  logic [15:0]     reg_data_i,
    output logic [15:0]     reg_data_o,
    input  logic [NSRC-1:0] req_i,
    input  logic            busy_i,
    output logic            trg_o,
    output logic [2:0]      trg_src_o,
    output logic [15:0]     trg_id_o
);

    localparam int IW = idx_w(NSRC);

    state_t          state_q, state_d;
    logic [NSRC-1:0] mask_q, pend_q, pend_d;
    logic [NSRC-1:0] act, gnt, clr_gnt, lost;
    logic [IW-1:0]   ptr_q, idx;
    logic [15:0]     hold_q, hcnt_q, trgcnt_q, lostcnt_q;
    logic [3:0]      nlost;
    logic [7:0]      pend8;
    logic            accept, cmd_clr;
    logic            wr_mask, wr_hold, wr_cnt, wr_lost, wr_id;

    assign wr_mask = reg_we_i && (reg_addr_i == ADDR_MASK);
    assign wr_hold = reg_we_i && (reg_addr_i == ADDR_HOLDOFF);
    assign wr_cnt  = reg_we_i && (reg_addr_i == ADDR_TRGCNT);
    assign wr_lost = reg_we_i && (reg_addr_i == ADDR_LOSTCNT);
    assign wr_id   = reg_we_i && (reg_addr_i == ADDR_TRGID);
    assign cmd_clr = reg_we_i && (reg_addr_i == ADDR_CMD)
                     && (reg_data_i == CMD_CLEAR);

    assign act = pend_q & mask_q;

    trg_rr_arb #(
        .NSRC (NSRC),
        .IW   (IW)
    ) u_rr (
        .req_i (act),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (idx)
    );

    // The grant decision is taken in IDLE so trg_o is high in FIRE.
    assign accept  = (state_q == ST_IDLE) && (|act) && !busy_i;
    assign clr_gnt = accept ? gnt : '0;
    assign lost    = req_i & mask_q & pend_q & ~clr_gnt;

    // Pending bits are kept masked, so clearing a MASK bit drops them.
    assign pend_d = cmd_clr ? '0
                  : ((pend_q & ~clr_gnt) | req_i) & mask_q;

    always_comb begin
        nlost = '0;
        for (int i = 0; i < NSRC; i++) begin
            nlost = nlost + 4'(lost[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept) state_d = ST_FIRE;
            ST_FIRE:    state_d = (hold_q != '0) ? ST_HOLDOFF : ST_IDLE;
            ST_HOLDOFF: if (hcnt_q <= 16'd1) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            mask_q  <= '0;
            hold_q  <= '0;
            hcnt_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (wr_mask) mask_q <= reg_data_i[NSRC-1:0];
            if (wr_hold) hold_q <= reg_data_i;
            // Count is latched on FIRE exit; HOLDOFF writes never reload it.
            if (state_q == ST_FIRE)
                hcnt_q <= hold_q;
            else if (state_q == ST_HOLDOFF)
                hcnt_q <= hcnt_q - 16'd1;
            if (accept)
                ptr_q <= (idx == IW'(NSRC - 1)) ? '0 : idx + IW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            trg_o     <= 1'b0;
            trg_src_o <= '0;
            trg_id_o  <= '0;
            trgcnt_q  <= '0;
            lostcnt_q <= '0;
        end else begin
            trg_o <= accept;
            if (accept) trg_src_o <= 3'(idx);
            if (cmd_clr)     trg_id_o <= '0;
            else if (wr_id)  trg_id_o <= reg_data_i;
            else if (accept) trg_id_o <= trg_id_o + 16'd1;
            if (cmd_clr)     trgcnt_q <= '0;
            else if (wr_cnt) trgcnt_q <= reg_data_i;
            else if (accept) trgcnt_q <= sat_add(trgcnt_q, 4'd1);
            if (cmd_clr)      lostcnt_q <= '0;
            else if (wr_lost) lostcnt_q <= reg_data_i;
            else if (|lost)   lostcnt_q <= sat_add(lostcnt_q, nlost);
        end
    end

    assign pend8 = 8'(pend_q);

    always_comb begin
        reg_data_o = RD_DEFAULT;
        case (reg_addr_i)
            ADDR_STATUS:  reg_data_o = {pend8, 5'b0, busy_i, state_q};
            ADDR_MASK:    reg_data_o = 16'(mask_q);
            ADDR_HOLDOFF: reg_data_o = hold_q;
            ADDR_TRGCNT:  reg_data_o = trgcnt_q;
            ADDR_LOSTCNT: reg_data_o = lostcnt_q;
            ADDR_TRGID:   reg_data_o = trg_id_o;
            default:      reg_data_o = RD_DEFAULT;
        endcase
    end

endmodule

// File: tb/tb_trg_arb.sv
// Self-checking bench for trg_arb: vector table, scoreboard of issued
// triggers, and directed multi-cycle sequences.
module tb_trg_arb;
    import trg_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_we;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata;
    logic [3:0]  req;
    logic        busy;
    logic        trg;
    logic [2:0]  trg_src;
    logic [15:0] trg_id;

    int nchk  = 0;
    int nfail = 0;

    typedef struct {
        logic [2:0]  src;
        logic [15:0] id;
    } sb_t;
    sb_t         sbq[$];
    logic [15:0] exp_id;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] req;
        logic       trg;
        logic [2:0] src;
    } vec_t;
    vec_t vt[8];

    trg_arb #(.NSRC(4)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .reg_we_i   (reg_we),
        .reg_addr_i (reg_addr),
        .reg_data_i (reg_wdata),
        .reg_data_o (reg_rdata),
        .req_i      (req),
        .busy_i     (busy),
        .trg_o      (trg),
        .trg_src_o  (trg_src),
        .trg_id_o   (trg_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [15:0] a,
                       input logic [15:0] e);
        nchk++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        reg_we    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        tick();
        reg_we = 1'b0;
    endtask

    task automatic rdchk(input string nm, input logic [7:0] a,
                         input logic [15:0] e);
        reg_addr = a;
        #1;
        chk(nm, reg_rdata, e);
    endtask

    task automatic push(input logic [2:0] s);
        sb_t t;
        exp_id = exp_id + 16'd1;
        t.src  = s;
        t.id   = exp_id;
        sbq.push_back(t);
    endtask

    task automatic no_trg(input string nm, input int n);
        repeat (n) begin
            tick();
            chk(nm, 16'(trg), 16'h0);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && trg) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_trg", 16'h1, 16'h0);
            end else begin
                sb_t t;
                t = sbq.pop_front();
                chk("sb_src", 16'(trg_src), 16'(t.src));
                chk("sb_id", trg_id, t.id);
            end
        end
    end

    function automatic bit hold_hit(input int c);
        int et[5] = '{2, 14, 26, 38, 50};
        for (int k = 0; k < 5; k++) if (et[k] == c) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        vt[0] = '{4'h1, 4'h1, 1'b1, 3'd0};
        vt[1] = '{4'h2, 4'h2, 1'b1, 3'd1};
        vt[2] = '{4'hB, 4'h4, 1'b0, 3'd0};
        vt[3] = '{4'h0, 4'hF, 1'b0, 3'd0};
        vt[4] = '{4'h4, 4'h4, 1'b1, 3'd2};
        vt[5] = '{4'h3, 4'h2, 1'b1, 3'd1};
        vt[6] = '{4'hF, 4'h8, 1'b1, 3'd3};
        vt[7] = '{4'h7, 4'h8, 1'b0, 3'd0};

        rst_n     = 1'b0;
        reg_we    = 1'b0;
        reg_addr  = 8'h00;
        reg_wdata = 16'h0;
        req       = 4'h0;
        busy      = 1'b0;
        exp_id    = 16'h0;
        tick(3);
        chk("rst_trg", 16'(trg), 16'h0);
        chk("rst_src", 16'(trg_src), 16'h0);
        chk("rst_id", trg_id, 16'h0);
        rst_n = 1'b1;
        tick();
        rdchk("rst_status", ADDR_STATUS, 16'h0000);
        rdchk("rst_mask", ADDR_MASK, 16'h0000);
        rdchk("rst_hold", ADDR_HOLDOFF, 16'h0000);
        rdchk("rst_trgcnt", ADDR_TRGCNT, 16'h0000);
        rdchk("rst_lost", ADDR_LOSTCNT, 16'h0000);
        rdchk("rd_undef07", 8'h07, 16'hF001);
        rdchk("rd_undefff", 8'hFF, 16'hF001);

        // Single-request vectors, HOLDOFF=0.
        for (int v = 0; v < 8; v++) begin
            wr(ADDR_MASK, 16'(vt[v].mask));
            if (vt[v].trg) push(vt[v].src);
            req = vt[v].req;
            tick();
            req = 4'h0;
            chk("vec_lat1", 16'(trg), 16'h0);
            tick();
            chk("vec_trg", 16'(trg), 16'(vt[v].trg));
            if (vt[v].trg) chk("vec_src", 16'(trg_src), 16'(vt[v].src));
            tick(3);
        end
        rdchk("vec_trgcnt", ADDR_TRGCNT, 16'd5);
        rdchk("vec_lost", ADDR_LOSTCNT, 16'd0);
        rdchk("vec_trgid", ADDR_TRGID, 16'd5);

        // All four at once: round robin from source 0, pulses 2 apart.
        wr(ADDR_MASK, 16'hF);
        for (int s = 0; s < 4; s++) push(3'(s));
        req = 4'hF;
        tick();
        req = 4'h0;
        for (int k = 2; k <= 9; k++) begin
            tick();
            chk("rr_trg", 16'(trg), (k % 2 == 0) ? 16'h1 : 16'h0);
            if (k % 2 == 0) chk("rr_src", 16'(trg_src), 16'(k / 2 - 1));
        end
        rdchk("rr_lost", ADDR_LOSTCNT, 16'd0);
        rdchk("rr_trgcnt", ADDR_TRGCNT, 16'd9);

        // Holdoff 10 with req[0] every 3 cycles.
        wr(ADDR_CMD, CMD_CLEAR);
        exp_id = 16'h0;
        rdchk("clr_trgcnt", ADDR_TRGCNT, 16'd0);
        wr(ADDR_HOLDOFF, 16'd10);
        wr(ADDR_MASK, 16'h1);
        tick(2);
        for (int s = 0; s < 5; s++) push(3'd0);
        for (int c = 0; c < 60; c++) begin
            req = (c < 40 && c % 3 == 0) ? 4'h1 : 4'h0;
            tick();
            chk("hold_trg", 16'(trg), 16'(hold_hit(c + 1)));
        end
        req = 4'h0;
        tick(12);
        rdchk("hold_lost", ADDR_LOSTCNT, 16'd9);
        rdchk("hold_trgcnt", ADDR_TRGCNT, 16'd5);

        // Busy veto: request held pending, fires 1 cycle after busy falls.
        wr(ADDR_HOLDOFF, 16'd0);
        wr(ADDR_MASK, 16'h2);
        busy = 1'b1;
        tick(5);
        push(3'd1);
        req = 4'h2;
        tick();
        req = 4'h0;
        no_trg("busy_trg", 95);
        busy = 1'b0;
        tick();
        chk("busy_release", 16'(trg), 16'h1);
        tick(3);

        // Disabled source ignored, then CMD clear during FIRE.
        req = 4'h4;
        tick();
        req = 4'h0;
        no_trg("dis_trg", 5);
        rdchk("dis_trgcnt", ADDR_TRGCNT, 16'd6);
        rdchk("dis_lost", ADDR_LOSTCNT, 16'd9);
        wr(ADDR_MASK, 16'h4);
        push(3'd2);
        req = 4'h4;
        tick();
        req = 4'h0;
        tick();
        chk("clr_fire_trg", 16'(trg), 16'h1);
        wr(ADDR_CMD, CMD_CLEAR);
        exp_id = 16'h0;
        chk("clr_fire_id", trg_id, 16'h0);
        rdchk("clr_fire_cnt", ADDR_TRGCNT, 16'd0);
        rdchk("clr_fire_lost", ADDR_LOSTCNT, 16'd0);

        // Saturation and ID wrap.
        wr(ADDR_TRGCNT, 16'hFFFF);
        wr(ADDR_TRGID, 16'hFFFF);
        wr(ADDR_MASK, 16'h1);
        exp_id = 16'hFFFF;
        push(3'd0);
        req = 4'h1;
        tick();
        req = 4'h0;
        tick();
        chk("wrap_trg", 16'(trg), 16'h1);
        chk("wrap_id", trg_id, 16'h0000);
        tick(2);
        rdchk("sat_trgcnt", ADDR_TRGCNT, 16'hFFFF);

        // Clearing a MASK bit drops the pending request.
        busy = 1'b1;
        req  = 4'h1;
        tick();
        req = 4'h0;
        tick();
        rdchk("pend_status", ADDR_STATUS, 16'h0104);
        wr(ADDR_MASK, 16'h0);
        tick();
        rdchk("pend_cleared", ADDR_STATUS, 16'h0004);
        busy = 1'b0;
        no_trg("mask_clr_trg", 4);
        wr(ADDR_MASK, 16'h1);
        no_trg("mask_re_trg", 3);

        // Asynchronous reset while a trigger is on the output.
        wr(ADDR_HOLDOFF, 16'd5);
        req = 4'h1;
        tick();
        req = 4'h0;
        tick();
        chk("prerst_trg", 16'(trg), 16'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_trg", 16'(trg), 16'h0);
        chk("arst_id", trg_id, 16'h0);
        rdchk("arst_status", ADDR_STATUS, 16'h0000);
        rdchk("arst_hold", ADDR_HOLDOFF, 16'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        rdchk("arst_mask", ADDR_MASK, 16'h0000);
        no_trg("post_rst_trg", 4);

        chk("sb_empty", 16'(sbq.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end

endmodule

// File: doc/trg_arb.md
# trg_arb

Trigger arbiter and scheduler for the ALPIDE DAQ trigger path. It merges up to NSRC trigger request sources into one trigger stream: the periodic sequencer, external/LEMO, software pulse and others. It applies a per-source enable mask, a readout busy veto and a programmable minimum spacing (holdoff). Each accepted trigger is issued as a single-cycle pulse with its source index and a running trigger ID; accepted and lost triggers are counted. It sits between the trigger sources and the chip control/readout front end and is configured over the 8-bit-address / 16-bit-data register bus.

## Interface
- NSRC, 4, number of request sources (2..8).
- clk_i  in  1  system clock; all logic is synchronous to it.
- rst_n_i  in  1  reset, asynchronous, active-low.
- reg_we_i  in  1  register write strobe.
- reg_addr_i  in  8  register address (block-local).
- reg_data_i  in  16  register write data.
- reg_data_o  out  16  register read data, combinational from reg_addr_i.
- req_i  in  NSRC  trigger requests, one-cycle pulses, synchronous to clk_i.
- busy_i  in  1  readout busy; while high no new trigger is issued.
- trg_o  out  1  accepted trigger, one-cycle pulse, registered.
- trg_src_o  out  3  index of the source that won the last trigger, registered.
- trg_id_o  out  16  ID of the last issued trigger, registered; wraps at 16 bits.

## Operation
- Registers (address: meaning, reset value):
  - 0x00 STATUS (read only): [1:0] state, [2] busy_i, [15:8] pending bits.
  - 0x01 MASK: [NSRC-1:0] source enable, reset 0 (all sources disabled).
  - 0x02 CMD (write only): 0x0001 clears TRGCNT, LOSTCNT, trg_id_o and all pending bits. Other values are ignored.
  - 0x03 HOLDOFF: 16 bits, reset 0.
  - 0x04 TRGCNT: accepted triggers, saturates at 0xFFFF.
  - 0x05 LOSTCNT: lost requests, saturates at 0xFFFF.
  - 0x06 TRGID: mirror of trg_id_o.
  - Any other address reads 0xF001.
- Pending bits: one per source.
  - A req_i pulse on an enabled source sets its pending bit.
  - A request on a disabled source is ignored and not counted.
  - Clearing a MASK bit also clears that source's pending bit.
- Lost requests: a request arriving while its pending bit is already set, and the bit is not being cleared this cycle, increments LOSTCNT.
- FSM states:
  - IDLE (0): go to FIRE when (pending & MASK) != 0 and busy_i == 0.
  - FIRE (1): assert trg_o. Round-robin grant starting from the source after the previous winner. Clear the winner's pending bit, load trg_src_o, increment trg_id_o and TRGCNT. Go to HOLDOFF if HOLDOFF != 0, else to IDLE.
  - HOLDOFF (2): load the down-counter with HOLDOFF on entry. Return to IDLE when the counter reaches 1. Exactly HOLDOFF cycles are spent in this state.
  - State 3 is unused and recovers to IDLE.
- busy_i is sampled only in IDLE. Pending bits persist through busy, so no request is dropped by busy alone.
- Simultaneous events:
  - A request on the granted source in the FIRE cycle re-sets its pending bit; it is not lost.
  - CMD clear in the same cycle as FIRE: clear wins, so counters and trg_id_o become 0. trg_o still pulses and trg_src_o still loads.
- Writes to MASK or HOLDOFF take effect on the next cycle. Changing HOLDOFF does not reload a running holdoff count.

## Timing
- Reset values: trg_o=0, trg_src_o=0, trg_id_o=0, state IDLE, counters 0, pending 0, round-robin pointer 0.
- Latency, request to trg_o: a req_i at cycle n sets pending at n+1. IDLE then moves to FIRE, so trg_o is high at cycle n+2 when the block is idle and not busy.
- trg_id_o and trg_src_o update in the same cycle trg_o is high.
- Minimum spacing between trg_o pulses is HOLDOFF+2 cycles.
- Reset asserted mid-operation forces all outputs and state to their reset values immediately (asynchronous). The first trigger after release needs a new request.

## Structure
- Shared package trg_pkg holds:
  - register address constants and CMD_CLEAR=16'h0001;
  - the state encoding (IDLE, FIRE, HOLDOFF);
  - the 0xF001 default read value.
- One sub-module, trg_rr_arb: NSRC-wide round-robin arbiter with a request vector and a pointer in, and a one-hot grant plus binary index out. Combinational, with the pointer register held in the parent.

## Test plan
- MASK=0x1, HOLDOFF=0, single pulse on req_i[0] at cycle n -> trg_o high at n+2, trg_src_o=0, trg_id_o=1, TRGCNT=1.
- MASK=0xF, all four sources pulse together -> four trg_o pulses, 2 cycles apart, trg_src_o 0,1,2,3, LOSTCNT=0.
- MASK=0x1, HOLDOFF=10, req_i[0] pulsed every 3 cycles for 40 cycles -> trg_o pulses 12 cycles apart, LOSTCNT equal to the number of requests that found pending already set.
- busy_i held high for 100 cycles while req_i[1] pulses once (MASK=0x2) -> no trg_o while busy; trg_o 1 cycle after busy_i falls.
- req_i[2] pulses with MASK[2]=0 -> no trg_o and no counter change. Then CMD=0x0001 in a FIRE cycle -> trg_o pulses and TRGCNT=0, trg_id_o=0 afterwards.
- Preset TRGCNT to 0xFFFF via stimulus, then one more trigger -> TRGCNT stays 0xFFFF and trg_id_o wraps from 0xFFFF to 0x0000.
